// File: rtl/queue_instr_pkg.sv
// Shared front-end sizing for the instruction queue: word width, default depth
// and the push/pop operation encoding used by the occupancy counter.
package queue_instr_pkg;

  localparam int IWIDTH  = 32;
  localparam int Q_DEPTH = 16;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

endpackage

// File: rtl/queue_instr.sv
// Instruction FIFO between fetch and issue with a registered read port.
// Optional sticky overflow/underflow flag q_o_err when QUEUE_INSTR_ERR_EN is defined.
module queue_instr
  import queue_instr_pkg::*;
#(
  parameter int DEPTH = Q_DEPTH
) (
  input  logic              q_clk,
  input  logic              q_rst,
  input  logic [IWIDTH-1:0] q_i_instr,
  input  logic              q_i_we,
  input  logic              q_i_re,
  output logic [IWIDTH-1:0] q_o_instr,
  output logic              q_o_full,
`ifdef QUEUE_INSTR_ERR_EN
  output logic              q_o_empty,
  output logic              q_o_err
`else
  output logic              q_o_empty
`endif
);

  localparam int AWIDTH = $clog2(DEPTH);

  logic [IWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wp;
  logic [AWIDTH-1:0] rp;
  logic [AWIDTH:0]   count;
  logic              push;
  logic              pop;
  q_op_e             op;

  assign q_o_full  = (count == (AWIDTH+1)'(DEPTH));
  assign q_o_empty = (count == '0);

  // Acceptance is judged on pre-edge flags, so a full queue still pops while its push drops.
  assign push = q_i_we && !q_o_full;
  assign pop  = q_i_re && !q_o_empty;
  assign op   = q_op_e'({push, pop});

  // Storage is never reset; reads only ever reach entries written since reset.
  always_ff @(posedge q_clk) begin
    if (push && !q_rst) begin
      mem[wp] <= q_i_instr;
    end
  end

  always_ff @(posedge q_clk) begin
    if (q_rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      q_o_instr <= '0;
    end else begin
      if (push) begin
        wp <= wp + AWIDTH'(1);
      end
      if (pop) begin
        rp        <= rp + AWIDTH'(1);
        q_o_instr <= mem[rp];
      end
      case (op)
        OP_PUSH: count <= count + (AWIDTH+1)'(1);
        OP_POP:  count <= count - (AWIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef QUEUE_INSTR_ERR_EN
  always_ff @(posedge q_clk) begin
    if (q_rst) begin
      q_o_err <= 1'b0;
    end else if ((q_i_we && q_o_full) || (q_i_re && q_o_empty)) begin
      q_o_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_instr.sv
// Self-checking bench for queue_instr: directed table, corner sequences and a
// randomized run against a queue-based reference model (QUEUE_INSTR_ERR_EN aware).
module tb_queue_instr;
  import queue_instr_pkg::*;

  localparam int DEPTH = Q_DEPTH;

  logic              q_clk = 1'b0;
  logic              q_rst;
  logic [IWIDTH-1:0] q_i_instr;
  logic              q_i_we;
  logic              q_i_re;
  logic [IWIDTH-1:0] q_o_instr;
  logic              q_o_full;
  logic              q_o_empty;
  logic              q_o_err;

  queue_instr #(.DEPTH(DEPTH)) dut (
    .q_clk     (q_clk),
    .q_rst     (q_rst),
    .q_i_instr (q_i_instr),
    .q_i_we    (q_i_we),
    .q_i_re    (q_i_re),
    .q_o_instr (q_o_instr),
    .q_o_full  (q_o_full),
`ifdef QUEUE_INSTR_ERR_EN
    .q_o_empty (q_o_empty),
    .q_o_err   (q_o_err)
`else
    .q_o_empty (q_o_empty)
`endif
  );

`ifndef QUEUE_INSTR_ERR_EN
  assign q_o_err = 1'b0;
`endif

  always #5 q_clk = ~q_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of words plus the last popped word.
  logic [IWIDTH-1:0] mq [$];
  logic [IWIDTH-1:0] m_out;
  logic              m_err;

  task automatic chk(input string name, input logic [IWIDTH-1:0] act, input logic [IWIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge with the given inputs, followed by a full model comparison.
  task automatic step(input logic rst, input logic we, input logic re, input logic [IWIDTH-1:0] din);
    logic was_full, was_empty;
    @(negedge q_clk);
    q_rst = rst; q_i_we = we; q_i_re = re; q_i_instr = din;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    @(posedge q_clk);
    if (rst) begin
      mq.delete();
      m_out = '0;
      m_err = 1'b0;
    end else begin
      if (re && !was_empty) m_out = mq.pop_front();
      if (we && !was_full) mq.push_back(din);
      if ((we && was_full) || (re && was_empty)) m_err = 1'b1;
    end
    #1;
    chk("mdl_out",   q_o_instr, m_out);
    chk("mdl_empty", IWIDTH'(q_o_empty), IWIDTH'(mq.size() == 0));
    chk("mdl_full",  IWIDTH'(q_o_full),  IWIDTH'(mq.size() == DEPTH));
`ifdef QUEUE_INSTR_ERR_EN
    chk("mdl_err",   IWIDTH'(q_o_err),   IWIDTH'(m_err));
`endif
  endtask

  typedef struct {
    logic              we;
    logic              re;
    logic [IWIDTH-1:0] din;
    logic [IWIDTH-1:0] exp_out;
    logic              exp_empty;
    logic              exp_full;
  } vec_t;

  vec_t vt [8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    q_rst = 1'b1; q_i_we = 1'b0; q_i_re = 1'b0; q_i_instr = '0;
    m_out = '0; m_err = 1'b0;

    // Reset held for two edges.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'hDEAD);
    chk("rst_out",   q_o_instr, '0);
    chk("rst_empty", IWIDTH'(q_o_empty), 1);
    chk("rst_full",  IWIDTH'(q_o_full),  0);

    // Directed table with hand-derived expectations.
    vt[0] = '{1'b1, 1'b0, 32'hA1, 32'h0,  1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 32'hA2, 32'h0,  1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 32'h0,  32'hA1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 32'hA3, 32'hA2, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 32'h0,  32'hA3, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 32'h0,  32'hA3, 1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b1, 32'hA4, 32'hA3, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 32'h0,  32'hA4, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, vt[i].we, vt[i].re, vt[i].din);
      chk($sformatf("tbl%0d_out", i),   q_o_instr, vt[i].exp_out);
      chk($sformatf("tbl%0d_empty", i), IWIDTH'(q_o_empty), IWIDTH'(vt[i].exp_empty));
      chk($sformatf("tbl%0d_full", i),  IWIDTH'(q_o_full),  IWIDTH'(vt[i].exp_full));
    end

    // Ordered transfer of 0..9.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, IWIDTH'(i));
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      chk($sformatf("ord%0d", i), q_o_instr, IWIDTH'(i));
    end
    chk("ord_empty", IWIDTH'(q_o_empty), 1);

    // Fill to full, overflow push dropped.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, IWIDTH'(i));
    chk("full_set", IWIDTH'(q_o_full), 1);
    step(1'b0, 1'b1, 1'b0, IWIDTH'(16));
    chk("full_hold", IWIDTH'(q_o_full), 1);
`ifdef QUEUE_INSTR_ERR_EN
    chk("ovf_err", IWIDTH'(q_o_err), 1);
`endif
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      chk($sformatf("drain%0d", i), q_o_instr, IWIDTH'(i));
    end
    chk("drain_empty", IWIDTH'(q_o_empty), 1);

    // Underflow after reading 0..5 holds the last word.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, IWIDTH'(i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("udf_hold", q_o_instr, 32'd5);
`ifdef QUEUE_INSTR_ERR_EN
    chk("udf_err", IWIDTH'(q_o_err), 1);
`endif

    // Full queue with push+pop: pop taken, push dropped.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, IWIDTH'(32'h200 + i));
    step(1'b0, 1'b1, 1'b1, 32'h2FF);
    chk("fullrw_out",  q_o_instr, 32'h200);
    chk("fullrw_full", IWIDTH'(q_o_full), 0);

    // Steady push+pop with 3 resident words, wrapping the pointers.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, IWIDTH'(100 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, IWIDTH'(103 + i));
      chk($sformatf("rw%0d", i), q_o_instr, IWIDTH'(100 + i));
      chk($sformatf("rw%0d_empty", i), IWIDTH'(q_o_empty), 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      chk($sformatf("rwtail%0d", i), q_o_instr, IWIDTH'(120 + i));
    end
    chk("rwtail_empty", IWIDTH'(q_o_empty), 1);

    // Reset with 5 queued words, then a fresh word must come out.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, IWIDTH'(32'h300 + i));
    step(1'b1, 1'b1, 1'b1, 32'h3FF);
    chk("mid_rst_empty", IWIDTH'(q_o_empty), 1);
    chk("mid_rst_out",   q_o_instr, '0);
    step(1'b0, 1'b1, 1'b0, 32'hABC);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("mid_rst_new", q_o_instr, 32'hABC);
    chk("mid_rst_new_empty", IWIDTH'(q_o_empty), 1);

    // Randomized traffic against the model, with phases biased to fill and drain.
    for (int i = 0; i < 1500; i++) begin
      int bias;
      bias = (i / 150) % 3;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5))),
           ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5))),
           IWIDTH'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
